// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared update datapath walks all
// neurons per timestep, then drains the resulting spikes as AER events in ascending order.
module lif_layer_scheduler #(
    parameter int unsigned N         = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned THRESHOLD = 5,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned LEAK_NUM  = 9,
    parameter int unsigned LEAK_DEN  = 10,
    parameter int unsigned WEIGHT    = 3,
    parameter int unsigned AW        = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_start,
    input  logic [N-1:0]     in_bits,
    output logic             busy,
    output logic             done,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [AW-1:0]    spike_addr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_potential
);

    localparam int unsigned PW = WIDTH + 8;
    localparam int unsigned SW = WIDTH + 9;

    typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pot [N];
    logic [N-1:0]     flags, flags_n;
    logic [N-1:0]     lin;
    logic [AW-1:0]    idx, idx_n;

    logic [PW-1:0]    prod, quot;
    logic [SW-1:0]    sum;
    logic [WIDTH-1:0] t_sat;
    logic             fire;
    logic [AW-1:0]    prio_addr;
    logic             valid_n;

    // Shared leak/integrate datapath for the neuron selected by idx
    always_comb begin
        prod  = PW'(pot[idx]) * PW'(LEAK_NUM);
        quot  = prod / PW'(LEAK_DEN);
        sum   = SW'(quot) + (lin[idx] ? SW'(WEIGHT) : SW'(0));
        t_sat = (|sum[SW-1:WIDTH]) ? '1 : sum[WIDTH-1:0];
        fire  = (SW'(t_sat) >= SW'(THRESHOLD));
    end

    // Next-state, index and spike-flag updates
    always_comb begin
        state_n = state;
        idx_n   = idx;
        flags_n = flags;
        case (state)
            IDLE: begin
                if (step_start) begin
                    state_n = UPDATE;
                    idx_n   = '0;
                    flags_n = '0;
                end
            end
            UPDATE: begin
                if (fire) begin
                    flags_n[idx] = 1'b1;
                end
                idx_n = idx + AW'(1);
                if (idx == AW'(N - 1)) begin
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (spike_valid && spike_ready) begin
                    flags_n[spike_addr] = 1'b0;
                end
                if (flags_n == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Lowest pending flag is the next event to present
    always_comb begin
        prio_addr = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (flags_n[i]) begin
                prio_addr = AW'(i);
            end
        end
        valid_n = (state_n == EMIT) && (flags_n != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            flags       <= '0;
            lin         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_addr  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                pot[i] <= '0;
            end
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            flags       <= flags_n;
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
            spike_valid <= valid_n;
            spike_addr  <= valid_n ? prio_addr : '0;
            if (state == IDLE && step_start) begin
                lin <= in_bits;
            end
            if (state == UPDATE) begin
                pot[idx] <= fire ? WIDTH'(RESET_VAL) : t_sat;
            end
        end
    end

    assign rd_potential = pot[rd_addr];

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: integration, leak, AER drain order, backpressure,
// busy-time start rejection and mid-timestep reset, all with hand-computed expectations.
module tb_lif_layer_scheduler;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_start;
    logic [7:0] in_bits;
    logic       busy;
    logic       done;
    logic       spike_valid;
    logic       spike_ready;
    logic [2:0] spike_addr;
    logic [2:0] rd_addr;
    logic [7:0] rd_potential;

    int tests = 0;
    int fails = 0;

    int got_addr[$];
    int got_n[$];
    int done_n;
    bit stall_bad;
    bit early_valid;

    lif_layer_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .step_start   (step_start),
        .in_bits      (in_bits),
        .busy         (busy),
        .done         (done),
        .spike_valid  (spike_valid),
        .spike_ready  (spike_ready),
        .spike_addr   (spike_addr),
        .rd_addr      (rd_addr),
        .rd_potential (rd_potential)
    );

    always #5 clk = ~clk;

    task automatic read_pot(input int i, output int val);
        rd_addr = 3'(i);
        #1;
        val = int'(rd_potential);
    endtask

    // Runs one timestep. n counts rising edges after the accepting edge; outputs are
    // sampled on the falling edge. Stops when done is seen, at abort_at, or after 64 edges.
    task automatic run_step(input logic [7:0] bits, input int stall, input bit poke,
                            input int abort_at);
        int n;
        int left;
        int held;
        got_addr.delete();
        got_n.delete();
        done_n      = -1;
        stall_bad   = 1'b0;
        early_valid = 1'b0;
        left        = stall;
        held        = -1;
        @(negedge clk);
        step_start  = 1'b1;
        in_bits     = bits;
        spike_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step_start = poke;
        in_bits    = poke ? 8'hFF : ~bits;
        n = 0;
        while (n < 64) begin
            if (n == abort_at) break;
            if (done) begin
                done_n = n;
                break;
            end
            if (spike_valid && n < N) early_valid = 1'b1;
            if (spike_valid) begin
                if (left > 0) begin
                    spike_ready = 1'b0;
                    if (held < 0) held = int'(spike_addr);
                    else if (int'(spike_addr) != held) stall_bad = 1'b1;
                    left--;
                end else begin
                    spike_ready = 1'b1;
                    if (held >= 0 && int'(spike_addr) != held) stall_bad = 1'b1;
                    held = -1;
                    got_addr.push_back(int'(spike_addr));
                    got_n.push_back(n);
                end
            end else begin
                spike_ready = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        step_start  = 1'b0;
        in_bits     = '0;
        spike_ready = 1'b1;
    endtask

    task automatic test_reset();
        int v;
        rst = 1'b1;
        step_start = 1'b1;
        in_bits = 8'hFF;
        spike_ready = 1'b1;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, spike_valid, spike_addr} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b addr=%0d, want all 0",
                     busy, done, spike_valid, spike_addr);
        end
        read_pot(5, v);
        tests++;
        if (v !== 0) begin
            fails++;
            $display("FAIL reset_pot5: got %0d, want 0", v);
        end
        step_start = 1'b0;
        in_bits = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_integrate();
        int v;
        run_step(8'h01, 0, 1'b0, -1);
        read_pot(0, v);
        tests++;
        if (v !== 3 || got_addr.size() !== 0) begin
            fails++;
            $display("FAIL integrate_step1: got p0=%0d spikes=%0d, want p0=3 spikes=0",
                     v, got_addr.size());
        end
        tests++;
        if (done_n !== N + 1) begin
            fails++;
            $display("FAIL integrate_done_time: got %0d, want %0d", done_n, N + 1);
        end
        run_step(8'h01, 0, 1'b0, -1);
        read_pot(0, v);
        tests++;
        if (got_addr.size() !== 1 || (got_addr.size() == 1 && got_addr[0] !== 0)) begin
            fails++;
            $display("FAIL integrate_step2_spike: got %0d events, want one at addr 0",
                     got_addr.size());
        end
        tests++;
        if (v !== 0) begin
            fails++;
            $display("FAIL integrate_step2_pot: got %0d, want 0", v);
        end
        tests++;
        if (early_valid !== 1'b0) begin
            fails++;
            $display("FAIL integrate_valid_outside_emit: got %b, want 0", early_valid);
        end
    endtask

    task automatic test_leak();
        int v;
        int exp_p[3] = '{2, 1, 0};
        run_step(8'h01, 0, 1'b0, -1);
        for (int s = 0; s < 3; s++) begin
            run_step(8'h00, 0, 1'b0, -1);
            read_pot(0, v);
            tests++;
            if (v !== exp_p[s] || got_addr.size() !== 0) begin
                fails++;
                $display("FAIL leak_step%0d: got p0=%0d spikes=%0d, want p0=%0d spikes=0",
                         s, v, got_addr.size(), exp_p[s]);
            end
        end
    endtask

    task automatic test_multi();
        int v;
        int exp_a[4] = '{0, 2, 5, 7};
        bit bad;
        run_step(8'hA5, 0, 1'b0, -1);
        read_pot(7, v);
        tests++;
        if (v !== 3 || got_addr.size() !== 0) begin
            fails++;
            $display("FAIL multi_step1: got p7=%0d spikes=%0d, want p7=3 spikes=0",
                     v, got_addr.size());
        end
        run_step(8'hA5, 0, 1'b0, -1);
        bad = (got_addr.size() != 4);
        for (int i = 0; i < 4 && !bad; i++) begin
            if (got_addr[i] != exp_a[i] || got_n[i] != N + i) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL multi_events: got %0d events, want addrs 0,2,5,7 at edges 8..11",
                     got_addr.size());
        end
        tests++;
        if (done_n !== N + 4) begin
            fails++;
            $display("FAIL multi_done_time: got %0d, want %0d", done_n, N + 4);
        end
        read_pot(5, v);
        tests++;
        if (v !== 0) begin
            fails++;
            $display("FAIL multi_pot5: got %0d, want 0", v);
        end
    endtask

    task automatic test_backpressure();
        int exp_a[4] = '{0, 2, 5, 7};
        bit bad;
        run_step(8'hA5, 0, 1'b0, -1);
        run_step(8'hA5, 4, 1'b0, -1);
        bad = (got_addr.size() != 4);
        for (int i = 0; i < 4 && !bad; i++) begin
            if (got_addr[i] != exp_a[i]) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL backpressure_events: got %0d events, want exactly 0,2,5,7",
                     got_addr.size());
        end
        tests++;
        if (stall_bad !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold: got addr changes=%b, want 0", stall_bad);
        end
        tests++;
        if (done_n !== N + 8) begin
            fails++;
            $display("FAIL backpressure_done_time: got %0d, want %0d", done_n, N + 8);
        end
    endtask

    task automatic test_busy_ignore();
        int v;
        bit nonzero;
        run_step(8'h00, 0, 1'b1, -1);
        tests++;
        if (done_n !== N + 1 || got_addr.size() !== 0) begin
            fails++;
            $display("FAIL busy_ignore_done: got done at %0d with %0d spikes, want %0d with 0",
                     done_n, got_addr.size(), N + 1);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_return: got busy=%b done=%b, want 0 0", busy, done);
        end
        nonzero = 1'b0;
        for (int i = 0; i < N; i++) begin
            read_pot(i, v);
            if (v != 0) nonzero = 1'b1;
        end
        tests++;
        if (nonzero !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_inputs: got nonzero potential=%b, want 0", nonzero);
        end
    endtask

    task automatic test_reset_mid_emit();
        int v;
        bit nonzero;
        bit saw_done;
        run_step(8'h5A, 0, 1'b0, -1);
        run_step(8'hA5, 0, 1'b0, -1);
        run_step(8'hA5, 0, 1'b0, N + 2);
        tests++;
        if (spike_valid !== 1'b1 || spike_addr !== 3'd5) begin
            fails++;
            $display("FAIL abort_pre: got valid=%b addr=%0d, want 1 5", spike_valid, spike_addr);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, spike_valid, spike_addr} !== 6'b0) begin
            fails++;
            $display("FAIL abort_outputs: got busy=%b done=%b valid=%b addr=%0d, want all 0",
                     busy, done, spike_valid, spike_addr);
        end
        nonzero = 1'b0;
        for (int i = 0; i < N; i++) begin
            read_pot(i, v);
            if (v != 0) nonzero = 1'b1;
        end
        tests++;
        if (nonzero !== 1'b0) begin
            fails++;
            $display("FAIL abort_pots: got nonzero potential=%b, want 0", nonzero);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || spike_valid) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got done/valid after abort=%b, want 0", saw_done);
        end
        run_step(8'h01, 0, 1'b0, -1);
        read_pot(0, v);
        tests++;
        if (v !== 3 || got_addr.size() !== 0 || done_n !== N + 1) begin
            fails++;
            $display("FAIL abort_recover: got p0=%0d spikes=%0d done=%0d, want 3 0 %0d",
                     v, got_addr.size(), done_n, N + 1);
        end
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_leak();
        test_multi();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
